// File: rtl/mem_req_arbiter.sv
// Two-requester (icache/dcache) memory request arbiter: round-robin grant on ties,
// one outstanding transaction, response timeout forces a bus error.

`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 512
`endif

package mem_req_arbiter_pkg;
    localparam int LINE_W = `ICACHE_LINE_WIDTH;

    typedef struct packed {
        logic [31:0]       address;
        logic              is_store;
        logic [LINE_W-1:0] store_data;
    } memory_request_t;
endpackage

// Per-requester response holding register: captures the line and error when the
// transaction it owns completes, then holds until its next completion.
module mem_req_arbiter_rsp_port #(
    parameter int W = 512
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_err,
    output logic [W-1:0] rsp_data,
    output logic         rsp_bus_error
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_data      <= '0;
            rsp_bus_error <= 1'b0;
        end else if (load) begin
            rsp_data      <= load_data;
            rsp_bus_error <= load_err;
        end
    end
endmodule

module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ic_req_valid,
    input  memory_request_t               ic_req_info,
    output logic                          ic_rsp_valid,
    output logic [`ICACHE_LINE_WIDTH-1:0] ic_rsp_data,
    output logic                          ic_rsp_bus_error,
    input  logic                          dc_req_valid,
    input  memory_request_t               dc_req_info,
    output logic                          dc_rsp_valid,
    output logic [`ICACHE_LINE_WIDTH-1:0] dc_rsp_data,
    output logic                          dc_rsp_bus_error,
    output logic                          mem_req_valid,
    output memory_request_t               mem_req_info,
    input  logic                          mem_rsp_valid,
    input  logic [`ICACHE_LINE_WIDTH-1:0] mem_rsp_data,
    input  logic                          mem_rsp_bus_error,
    output logic                          busy,
    output logic                          grant_owner
);
    localparam int       NUM_PORTS = 2;
    localparam int       W         = `ICACHE_LINE_WIDTH;
    localparam logic [7:0] TMO_LAST = 8'(RSP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d, last_grant_q, take;
    logic [7:0]      cnt_q;
    memory_request_t req_info_q;
    logic            timeout, rsp_done;
    logic [W-1:0]    fill_data;
    logic            fill_err;

    logic [NUM_PORTS-1:0]        rsp_vld, rsp_err;
    logic [NUM_PORTS-1:0][W-1:0] rsp_data;

    assign timeout   = (cnt_q == TMO_LAST);
    assign rsp_done  = (state_q == WAIT) && (mem_rsp_valid || timeout);
    // A real response always beats a coinciding timeout.
    assign fill_data = mem_rsp_valid ? mem_rsp_data : '0;
    assign fill_err  = mem_rsp_valid ? mem_rsp_bus_error : 1'b1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ic_req_valid || dc_req_valid) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                    owner_d = (ic_req_valid && dc_req_valid) ? ~last_grant_q : dc_req_valid;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (rsp_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            req_info_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                owner_q    <= owner_d;
                req_info_q <= owner_d ? dc_req_info : ic_req_info;
            end
            if (state_q == ISSUE)
                cnt_q <= '0;
            else if (state_q == WAIT && !mem_rsp_valid && !timeout)
                cnt_q <= cnt_q + 8'd1;
            if (state_q == RESP)
                last_grant_q <= owner_q;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_port
            mem_req_arbiter_rsp_port #(.W(W)) u_port (
                .clock         (clock),
                .reset         (reset),
                .load          (rsp_done && (owner_q == 1'(g))),
                .load_data     (fill_data),
                .load_err      (fill_err),
                .rsp_data      (rsp_data[g]),
                .rsp_bus_error (rsp_err[g])
            );
            assign rsp_vld[g] = (state_q == RESP) && (owner_q == 1'(g));
        end
    endgenerate

    assign ic_rsp_valid     = rsp_vld[0];
    assign ic_rsp_data      = rsp_data[0];
    assign ic_rsp_bus_error = rsp_err[0];
    assign dc_rsp_valid     = rsp_vld[1];
    assign dc_rsp_data      = rsp_data[1];
    assign dc_rsp_bus_error = rsp_err[1];
    assign mem_req_valid    = (state_q == ISSUE);
    assign mem_req_info     = req_info_q;
    assign busy             = (state_q != IDLE);
    assign grant_owner      = owner_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (RSP_TIMEOUT = 8).
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;
    localparam int W = LINE_W;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ic_req_valid = 1'b0, dc_req_valid = 1'b0;
    memory_request_t ic_req_info = '0, dc_req_info = '0;
    logic ic_rsp_valid, dc_rsp_valid, ic_rsp_bus_error, dc_rsp_bus_error;
    logic [W-1:0] ic_rsp_data, dc_rsp_data;
    logic mem_req_valid;
    memory_request_t mem_req_info;
    logic mem_rsp_valid = 1'b0, mem_rsp_bus_error = 1'b0;
    logic [W-1:0] mem_rsp_data = '0;
    logic busy, grant_owner;

    int errors = 0;
    int checks = 0;

    mem_req_arbiter #(.RSP_TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_info(ic_req_info),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_bus_error(ic_rsp_bus_error),
        .dc_req_valid(dc_req_valid), .dc_req_info(dc_req_info),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_rsp_bus_error(dc_rsp_bus_error),
        .mem_req_valid(mem_req_valid), .mem_req_info(mem_req_info),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_bus_error(mem_rsp_bus_error),
        .busy(busy), .grant_owner(grant_owner)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for the mem_req_valid pulse; returns at the sample point that shows it.
    task automatic wait_mem_req(output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            waited++;
            if (mem_req_valid) ok = 1'b1;
        end
    endtask

    // Serve one transaction: mem_rsp_valid is driven in the lat-th cycle after
    // mem_req_valid; returns at the sample point of the RESP cycle.
    task automatic serve(input int lat, input logic [W-1:0] data, input logic err,
                         output bit ok, output logic owner, output int waited);
        wait_mem_req(ok, waited);
        owner = grant_owner;
        repeat (lat) tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data = data;
        mem_rsp_bus_error = err;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_bus_error = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, grant_owner, mem_req_valid, ic_rsp_valid, dc_rsp_valid, ic_rsp_bus_error, dc_rsp_bus_error} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b owner=%b mreq=%b icv=%b dcv=%b icerr=%b dcerr=%b, want all 0",
                     busy, grant_owner, mem_req_valid, ic_rsp_valid, dc_rsp_valid, ic_rsp_bus_error, dc_rsp_bus_error);
        end
        checks++;
        if (mem_req_info !== '0 || ic_rsp_data !== '0 || dc_rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h icdata=%h dcdata=%h, want 0", mem_req_info.address, ic_rsp_data, dc_rsp_data);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_tie_from_reset();
        bit ok; logic own; int waited;
        logic [W-1:0] d1, d2;
        d1 = {(W/8){8'h11}};
        d2 = {(W/8){8'h22}};
        ic_req_info = '0; ic_req_info.address = 32'h0000_2000;
        dc_req_info = '0; dc_req_info.address = 32'h0000_3000; dc_req_info.is_store = 1'b1;
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        serve(1, d1, 1'b0, ok, own, waited);
        checks++;
        if (!ok || own !== 1'b0) begin
            errors++;
            $display("FAIL tie_first_owner: got ok=%0d owner=%b, want ok=1 owner=0", ok, own);
        end
        checks++;
        if (ic_rsp_valid !== 1'b1 || dc_rsp_valid !== 1'b0 || ic_rsp_data !== d1) begin
            errors++;
            $display("FAIL tie_first_rsp: got icv=%b dcv=%b data=%h, want icv=1 dcv=0 data=%h", ic_rsp_valid, dc_rsp_valid, ic_rsp_data, d1);
        end
        tick();
        ic_req_valid = 1'b0;
        serve(1, d2, 1'b0, ok, own, waited);
        checks++;
        if (!ok || own !== 1'b1 || waited != 1) begin
            errors++;
            $display("FAIL tie_second_grant: got ok=%0d owner=%b wait=%0d, want ok=1 owner=1 wait=1", ok, own, waited);
        end
        checks++;
        if (dc_rsp_valid !== 1'b1 || ic_rsp_valid !== 1'b0 || dc_rsp_data !== d2 || ic_rsp_data !== d1) begin
            errors++;
            $display("FAIL tie_second_rsp: got dcv=%b icv=%b dcdata=%h icdata=%h, want dcv=1 icv=0 dcdata=%h icdata=%h",
                     dc_rsp_valid, ic_rsp_valid, dc_rsp_data, ic_rsp_data, d2, d1);
        end
        tick();
        dc_req_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL tie_no_regrant: got busy=%b mreq=%b, want 0 0", busy, mem_req_valid);
        end
    endtask

    task automatic test_round_robin();
        bit ok; logic own; int waited;
        logic [3:0] seq;
        seq = '0;
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(2, {(W/8){8'(8'h40 + i)}}, 1'b0, ok, own, waited);
            seq[i] = own;
            tick();
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        checks++;
        if (seq !== 4'b1010) begin
            errors++;
            $display("FAIL rr_sequence: got owners(3..0)=%b, want 1010", seq);
        end
        tick();
    endtask

    task automatic test_single_ic();
        bit ok; int waited;
        memory_request_t exp;
        logic [W-1:0] dab;
        dab = {(W/8){8'hAB}};
        ic_req_info = '0;
        ic_req_info.address = 32'h0000_1000;
        exp = ic_req_info;
        ic_req_valid = 1'b1;
        wait_mem_req(ok, waited);
        checks++;
        if (!ok || mem_req_info !== exp || grant_owner !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: got ok=%0d addr=%h owner=%b busy=%b, want ok=1 addr=00001000 owner=0 busy=1",
                     ok, mem_req_info.address, grant_owner, busy);
        end
        tick();
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_req_pulse: got mreq=%b one cycle later, want 0", mem_req_valid);
        end
        tick();
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data = dab;
        checks++;
        if (ic_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_rsp: got icv=%b before memory answered, want 0", ic_rsp_valid);
        end
        tick();
        mem_rsp_valid = 1'b0;
        checks++;
        if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== dab || ic_rsp_bus_error !== 1'b0 || dc_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got icv=%b err=%b dcv=%b data=%h, want icv=1 err=0 dcv=0 data=%h",
                     ic_rsp_valid, ic_rsp_bus_error, dc_rsp_valid, ic_rsp_data, dab);
        end
        tick();
        ic_req_valid = 1'b0;
        checks++;
        if (ic_rsp_valid !== 1'b0 || busy !== 1'b0 || ic_rsp_data !== dab) begin
            errors++;
            $display("FAIL single_after: got icv=%b busy=%b data=%h, want icv=0 busy=0 data held %h",
                     ic_rsp_valid, busy, ic_rsp_data, dab);
        end
        tick();
    endtask

    task automatic test_timeout();
        bit ok; int waited; int lat;
        dc_req_info = '0;
        dc_req_info.address = 32'h0000_5000;
        dc_req_valid = 1'b1;
        wait_mem_req(ok, waited);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick();
            if (dc_rsp_valid) lat = i;
        end
        checks++;
        if (!ok || lat != 9) begin
            errors++;
            $display("FAIL timeout_latency: got ok=%0d latency=%0d, want ok=1 latency=9", ok, lat);
        end
        checks++;
        if (dc_rsp_bus_error !== 1'b1 || dc_rsp_data !== '0 || ic_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rsp: got err=%b icv=%b data=%h, want err=1 icv=0 data=0", dc_rsp_bus_error, ic_rsp_valid, dc_rsp_data);
        end
        tick();
        dc_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_bus_error();
        bit ok; logic own; int waited;
        logic [W-1:0] d;
        d = {(W/8){8'h5A}};
        ic_req_valid = 1'b1;
        serve(2, d, 1'b1, ok, own, waited);
        checks++;
        if (ic_rsp_valid !== 1'b1 || ic_rsp_bus_error !== 1'b1 || ic_rsp_data !== d) begin
            errors++;
            $display("FAIL bus_error_rsp: got icv=%b err=%b data=%h, want icv=1 err=1 data=%h", ic_rsp_valid, ic_rsp_bus_error, ic_rsp_data, d);
        end
        tick();
        ic_req_valid = 1'b0;
        tick();
        // response lands in the same cycle the timeout would fire
        d = {(W/8){8'hC3}};
        ic_req_valid = 1'b1;
        serve(8, d, 1'b0, ok, own, waited);
        checks++;
        if (ic_rsp_valid !== 1'b1 || ic_rsp_bus_error !== 1'b0 || ic_rsp_data !== d) begin
            errors++;
            $display("FAIL timeout_race: got icv=%b err=%b data=%h, want icv=1 err=0 data=%h", ic_rsp_valid, ic_rsp_bus_error, ic_rsp_data, d);
        end
        tick();
        ic_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_ignore_and_hold();
        bit ok; int waited;
        memory_request_t exp;
        logic [W-1:0] d;
        d = {(W/8){8'h77}};
        mem_rsp_valid = 1'b1;
        mem_rsp_data = {(W/8){8'hEE}};
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || ic_rsp_valid !== 1'b0 || dc_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: got busy=%b icv=%b dcv=%b, want 0 0 0", busy, ic_rsp_valid, dc_rsp_valid);
        end
        ic_req_info = '0;
        ic_req_info.address = 32'h0000_7000;
        exp = ic_req_info;
        ic_req_valid = 1'b1;
        wait_mem_req(ok, waited);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = {(W/8){8'hEE}};
        ic_req_info.address = 32'h0000_9999;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        checks++;
        if (ic_rsp_valid !== 1'b0 || busy !== 1'b1 || mem_req_info !== exp) begin
            errors++;
            $display("FAIL ignore_issue: got icv=%b busy=%b addr=%h, want icv=0 busy=1 addr=%h", ic_rsp_valid, busy, mem_req_info.address, exp.address);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data = d;
        tick();
        checks++;
        if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== d) begin
            errors++;
            $display("FAIL ignore_real_rsp: got icv=%b data=%h, want icv=1 data=%h", ic_rsp_valid, ic_rsp_data, d);
        end
        mem_rsp_data = {(W/8){8'hEE}};
        tick();
        mem_rsp_valid = 1'b0;
        ic_req_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || ic_rsp_valid !== 1'b0 || ic_rsp_data !== d) begin
            errors++;
            $display("FAIL ignore_resp: got busy=%b icv=%b data=%h, want busy=0 icv=0 data=%h", busy, ic_rsp_valid, ic_rsp_data, d);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; logic own; int waited; int seen;
        dc_req_info = '0;
        dc_req_info.address = 32'h0000_A000;
        dc_req_valid = 1'b1;
        wait_mem_req(ok, waited);
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, grant_owner, mem_req_valid, dc_rsp_valid, dc_rsp_bus_error, ic_rsp_bus_error} !== 6'b0 ||
            mem_req_info !== '0 || dc_rsp_data !== '0 || ic_rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b owner=%b mreq=%b dcv=%b addr=%h dcdata=%h, want all 0",
                     busy, grant_owner, mem_req_valid, dc_rsp_valid, mem_req_info.address, dc_rsp_data);
        end
        dc_req_valid = 1'b0;
        tick();
        reset = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = {(W/8){8'hDD}};
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_rsp_valid = 1'b0;
            if (ic_rsp_valid || dc_rsp_valid || busy) seen++;
        end
        checks++;
        if (seen != 0 || dc_rsp_data !== '0) begin
            errors++;
            $display("FAIL late_rsp: got %0d active cycles dcdata=%h, want 0 cycles data 0", seen, dc_rsp_data);
        end
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        serve(1, {(W/8){8'h99}}, 1'b0, ok, own, waited);
        checks++;
        if (!ok || own !== 1'b0 || ic_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_last_grant: got ok=%0d owner=%b icv=%b, want ok=1 owner=0 icv=1", ok, own, ic_rsp_valid);
        end
        tick();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_tie_from_reset();
        test_round_robin();
        test_single_ic();
        test_timeout();
        test_bus_error();
        test_ignore_and_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
